// File: rtl/count_ud_pkg.sv
// Shared definitions for the sliced up/down counter: default sizes, step direction
// encoding and the slice-count helper used by the top level.
package count_ud_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_SLICE_W = 4;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_e;

    function automatic int sliceCount(input int width, input int sliceW);
        return width / sliceW;
    endfunction

endpackage

// File: rtl/count_ud_slice.sv
// One SLICE_W-bit register of the counter chain: load, increment or decrement on the
// enables computed by the top, with all-ones / all-zeros flags for the lookahead chain.
module count_ud_slice
    import count_ud_pkg::*;
#(
    parameter int                 SLICE_W = DEFAULT_SLICE_W,
    parameter logic [SLICE_W-1:0] RST_VAL = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ld_i,
    input  logic [SLICE_W-1:0] din_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [SLICE_W-1:0] q_o,
    output logic               utc_o,
    output logic               dtc_o
);

    logic [SLICE_W-1:0] r_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= RST_VAL;
        end else if (ld_i) begin
            r_q <= din_i;
        end else if (inc_i) begin
            r_q <= r_q + SLICE_W'(1);
        end else if (dec_i) begin
            r_q <= r_q - SLICE_W'(1);
        end
    end

    assign q_o   = r_q;
    assign utc_o = &r_q;
    assign dtc_o = ~|r_q;

endmodule

// File: rtl/count_ud_param.sv
// Parametrised up/down counter with load, built from count_ud_slice instances joined by
// a lookahead carry/borrow chain. Define COUNT_UD_PARAM_SAT_EN for saturating mode.
module count_ud_param
    import count_ud_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter int               SLICE_W = DEFAULT_SLICE_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             dw_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] q_o,
    output logic             utc_o,
    output logic             dtc_o,
    output logic             wrap_o
);

    localparam int NSLICE = sliceCount(WIDTH, SLICE_W);

    generate
        if ((SLICE_W < 1) || (SLICE_W > 8) || (WIDTH % SLICE_W != 0)) begin : g_badParam
            $error("count_ud_param: WIDTH must be a multiple of SLICE_W and SLICE_W in 1..8");
        end
    endgenerate

    dir_e              w_dir;
    logic [WIDTH-1:0]  w_q;
    logic [NSLICE-1:0] w_sliceUtc;
    logic [NSLICE-1:0] w_sliceDtc;
    logic [NSLICE-1:0] w_lowOnes;
    logic [NSLICE-1:0] w_lowZeros;
    logic              w_utc;
    logic              w_dtc;
    logic              w_stepUp;
    logic              w_stepDn;
    logic              w_wrapEvt;
    logic              r_wrap;

    always_comb begin
        w_dir = DIR_HOLD;
        if (en_i && (up_i ^ dw_i)) begin
            w_dir = up_i ? DIR_UP : DIR_DN;
        end
    end

    assign w_utc = &w_sliceUtc;
    assign w_dtc = &w_sliceDtc;

    // A blocked step at a terminal count still reports through wrap_o as a saturation flag.
`ifdef COUNT_UD_PARAM_SAT_EN
    assign w_stepUp = (w_dir == DIR_UP) && !w_utc;
    assign w_stepDn = (w_dir == DIR_DN) && !w_dtc;
`else
    assign w_stepUp = (w_dir == DIR_UP);
    assign w_stepDn = (w_dir == DIR_DN);
`endif

    assign w_wrapEvt = ((w_dir == DIR_UP) && w_utc) || ((w_dir == DIR_DN) && w_dtc);

    genvar k;
    generate
        for (k = 0; k < NSLICE; k++) begin : g_slice
            // Each slice looks directly at every lower slice flag, so no carry ripples through slices.
            localparam logic [NSLICE-1:0] LOW_MASK = {NSLICE{1'b1}} >> (NSLICE - k);

            assign w_lowOnes[k]  = &(w_sliceUtc | ~LOW_MASK);
            assign w_lowZeros[k] = &(w_sliceDtc | ~LOW_MASK);

            count_ud_slice #(
                .SLICE_W (SLICE_W),
                .RST_VAL (RST_VAL[k*SLICE_W +: SLICE_W])
            ) u_slice (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .ld_i  (ld_i),
                .din_i (din_i[k*SLICE_W +: SLICE_W]),
                .inc_i (w_stepUp && w_lowOnes[k]),
                .dec_i (w_stepDn && w_lowZeros[k]),
                .q_o   (w_q[k*SLICE_W +: SLICE_W]),
                .utc_o (w_sliceUtc[k]),
                .dtc_o (w_sliceDtc[k])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrap <= 1'b0;
        end else if (ld_i) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrapEvt;
        end
    end

    assign q_o    = w_q;
    assign utc_o  = w_utc;
    assign dtc_o  = w_dtc;
    assign wrap_o = r_wrap;

endmodule

// File: tb/tb_count_ud_param.sv
// Self-checking bench for count_ud_param: a 16-bit/4-bit-slice and a 12-bit/3-bit-slice
// instance share stimulus and are compared every cycle against an arithmetic model.
module tb_count_ud_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        dw;
    logic        ld;
    logic [15:0] din;
    logic [11:0] din12;

    logic [15:0] q16;
    logic        utc16;
    logic        dtc16;
    logic        wrap16;
    logic [11:0] q12;
    logic        utc12;
    logic        dtc12;
    logic        wrap12;

    int unsigned m16;
    int unsigned m12;
    bit          mw16;
    bit          mw12;
    bit          checkOn;
    int          compared;
    int          mismatched;

    assign din12 = din[11:0];

    count_ud_param #(
        .WIDTH   (16),
        .SLICE_W (4),
        .RST_VAL (16'h1234)
    ) u_dut16 (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .up_i   (up),
        .dw_i   (dw),
        .ld_i   (ld),
        .din_i  (din),
        .q_o    (q16),
        .utc_o  (utc16),
        .dtc_o  (dtc16),
        .wrap_o (wrap16)
    );

    count_ud_param #(
        .WIDTH   (12),
        .SLICE_W (3),
        .RST_VAL (12'h5A5)
    ) u_dut12 (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .up_i   (up),
        .dw_i   (dw),
        .ld_i   (ld),
        .din_i  (din12),
        .q_o    (q12),
        .utc_o  (utc12),
        .dtc_o  (dtc12),
        .wrap_o (wrap12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Next state of an ideal counter whose largest value is maxv, straight from the rules.
    task automatic modelNext(input int unsigned q, input int unsigned maxv, input bit ldB,
                             input bit enB, input bit upB, input bit dwB, input int unsigned dinV,
                             output int unsigned nq, output bit nw);
        nq = q;
        nw = 1'b0;
        if (ldB) begin
            nq = dinV & maxv;
        end else if (enB && (upB != dwB)) begin
            if (upB) begin
                if (q == maxv) begin
                    nw = 1'b1;
`ifdef COUNT_UD_PARAM_SAT_EN
                    nq = maxv;
`else
                    nq = 0;
`endif
                end else begin
                    nq = q + 1;
                end
            end else begin
                if (q == 0) begin
                    nw = 1'b1;
`ifdef COUNT_UD_PARAM_SAT_EN
                    nq = 0;
`else
                    nq = maxv;
`endif
                end else begin
                    nq = q - 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit enB, input bit upB, input bit dwB, input bit ldB,
                                 input logic [15:0] dinV);
        int unsigned nq;
        bit          nw;
        @(negedge clk);
        en  = enB;
        up  = upB;
        dw  = dwB;
        ld  = ldB;
        din = dinV;
        @(posedge clk);
        #1;
        modelNext(m16, 32'hFFFF, ldB, enB, upB, dwB, {16'h0, dinV}, nq, nw);
        m16  = nq;
        mw16 = nw;
        modelNext(m12, 32'hFFF, ldB, enB, upB, dwB, {16'h0, dinV}, nq, nw);
        m12  = nq;
        mw12 = nw;
    endtask

    // Reset lands between edges so the check proves it acts without a clock.
    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        up  = 1'b0;
        dw  = 1'b0;
        ld  = 1'b0;
        #1;
        checkOutput("asyncRstQ16", {16'h0, q16}, 32'h1234);
        checkOutput("asyncRstWrap16", {31'h0, wrap16}, 32'h0);
        checkOutput("asyncRstQ12", {20'h0, q12}, 32'h5A5);
        m16  = 32'h1234;
        m12  = 32'h5A5;
        mw16 = 1'b0;
        mw12 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("q16", {16'h0, q16}, m16);
            checkOutput("utc16", {31'h0, utc16}, {31'h0, m16 == 32'hFFFF});
            checkOutput("dtc16", {31'h0, dtc16}, {31'h0, m16 == 32'h0});
            checkOutput("wrap16", {31'h0, wrap16}, {31'h0, mw16});
            checkOutput("q12", {20'h0, q12}, m12);
            checkOutput("utc12", {31'h0, utc12}, {31'h0, m12 == 32'hFFF});
            checkOutput("dtc12", {31'h0, dtc12}, {31'h0, m12 == 32'h0});
            checkOutput("wrap12", {31'h0, wrap12}, {31'h0, mw12});
        end
    end

    initial begin
        logic [15:0] pick;
        compared   = 0;
        mismatched = 0;
        checkOn    = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        up  = 1'b0;
        dw  = 1'b0;
        ld  = 1'b0;
        din = 16'h0;
        m16  = 32'h1234;
        m12  = 32'h5A5;
        mw16 = 1'b0;
        mw12 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstQ16", {16'h0, q16}, 32'h1234);
        checkOutput("rstWrap16", {31'h0, wrap16}, 32'h0);
        checkOutput("rstQ12", {20'h0, q12}, 32'h5A5);
        rst     = 1'b0;
        checkOn = 1'b1;

        // Count a little, reset mid-count, then resume from the reset value.
        repeat (3) applyStimulus(1, 1, 0, 0, 16'h0);
        checkOutput("preRstCount", {16'h0, q16}, 32'h1237);
        pulseReset();
        applyStimulus(1, 1, 0, 0, 16'h0);
        checkOutput("postRstUp", {16'h0, q16}, 32'h1235);

        // Carry across slice boundaries.
        applyStimulus(1, 0, 0, 1, 16'h00FF);
        applyStimulus(1, 1, 0, 0, 16'h0);
        checkOutput("carry0100", {16'h0, q16}, 32'h0100);
        checkOutput("carryUtc", {31'h0, utc16}, 32'h0);

        applyStimulus(0, 0, 0, 1, 16'hFFFF);
        checkOutput("ldFFFFutc", {31'h0, utc16}, 32'h1);
        applyStimulus(1, 1, 0, 0, 16'h0);
`ifdef COUNT_UD_PARAM_SAT_EN
        checkOutput("upAtMaxQ", {16'h0, q16}, 32'hFFFF);
`else
        checkOutput("upAtMaxQ", {16'h0, q16}, 32'h0000);
        checkOutput("upAtMaxDtc", {31'h0, dtc16}, 32'h1);
`endif
        checkOutput("upAtMaxWrap", {31'h0, wrap16}, 32'h1);
        applyStimulus(0, 0, 0, 0, 16'h0);
        checkOutput("wrapOneCycle", {31'h0, wrap16}, 32'h0);

        applyStimulus(0, 0, 0, 1, 16'h0000);
        applyStimulus(1, 0, 1, 0, 16'h0);
`ifdef COUNT_UD_PARAM_SAT_EN
        checkOutput("dnAtZeroQ", {16'h0, q16}, 32'h0000);
`else
        checkOutput("dnAtZeroQ", {16'h0, q16}, 32'hFFFF);
`endif
        checkOutput("dnAtZeroWrap", {31'h0, wrap16}, 32'h1);

        // Conflicting requests or disabled count must hold.
        applyStimulus(0, 0, 0, 1, 16'h7FFF);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i[0], 1, i[0], 0, 16'h0);
            checkOutput("holdQ", {16'h0, q16}, 32'h7FFF);
            checkOutput("holdWrap", {31'h0, wrap16}, 32'h0);
        end

        applyStimulus(1, 1, 0, 1, 16'hABCD);
        checkOutput("ldWinsQ16", {16'h0, q16}, 32'hABCD);
        checkOutput("ldWinsQ12", {20'h0, q12}, 32'hBCD);
        applyStimulus(0, 0, 0, 1, 16'h0FFF);
        applyStimulus(1, 1, 0, 0, 16'h0);
`ifdef COUNT_UD_PARAM_SAT_EN
        checkOutput("q12UpAtMax", {20'h0, q12}, 32'hFFF);
`else
        checkOutput("q12UpAtMax", {20'h0, q12}, 32'h000);
`endif
        checkOutput("q12Wrap", {31'h0, wrap12}, 32'h1);
        checkOutput("q16After0FFF", {16'h0, q16}, 32'h1000);

        // Random traffic biased toward the terminal counts.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: pick = 16'hFFFF;
                1: pick = 16'h0000;
                2: pick = 16'h0FFF;
                3: pick = 16'hFFFE;
                4: pick = 16'h0001;
                default: pick = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                              $urandom_range(0, 15) == 0, pick);
            end
        end

        applyStimulus(0, 0, 0, 0, 16'h0);
        @(negedge clk);
        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
